input_ram_reader: RTL and testbench

- Read-side sequencer for the layer input buffer RAM.
- On `start`, issues `length` consecutive read addresses from `base_addr` (wrapping modulo 2**A_WIDTH).
- Absorbs the RAM's one-cycle registered-address read latency and streams the words to the neuron datapath over a valid/ready interface with a last flag.
- Sits between the input buffer RAM and the first MAC stage.

---
 rtl/dnn_pkg.sv | 15 +
 rtl/reader_skid_fifo.sv | 58 +++++
 rtl/input_ram_reader.sv | 207 ++++++++++++++++++++
 tb/tb_input_ram_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared definitions for the layer-input datapath.
//   DEF_D_WIDTH / DEF_A_WIDTH : default RAM data / address widths
//   LEN_WIDTH                 : burst length width for the default address width
//   rd_state_e                : input RAM reader sequencer states
package dnn_pkg;
  localparam int DEF_D_WIDTH = 16;
  localparam int DEF_A_WIDTH = 4;
  localparam int LEN_WIDTH   = DEF_A_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry register FIFO sitting between the RAM read port and the stream
// output. Entry 0 is always the head, so rdata comes straight from a flop.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push/wdata : write one entry (caller guarantees room)
//   pop        : drop the head (caller guarantees count != 0)
//   rdata      : head entry
//   count      : occupancy 0..2
module reader_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   occ;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    occ     = count_q;
    if (pop) begin
      slot0_d = slot1_q;
      occ     = count_q - 2'd1;
    end
    if (push) begin
      // Land the new word in the first free slot after any pop this cycle.
      if (occ == 2'd0) slot0_d = wdata;
      else             slot1_d = wdata;
      count_d = occ + 2'd1;
    end else begin
      count_d = occ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign rdata = slot0_q;
  assign count = count_q;
endmodule

// File: rtl/input_ram_reader.sv
// Read-side sequencer for the layer input buffer RAM. On start it reads
// `length` consecutive addresses from base_addr (wrapping), absorbs the RAM's
// one-cycle read latency, and streams the words over valid/ready with a last
// flag. Optional replay is enabled with the macro INPUT_RAM_READER_REPEAT_EN.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start/base_addr/length : burst request, taken only in IDLE
//   r_addr, ram_data       : RAM read port (data valid the cycle after r_addr)
//   out_data/out_valid/out_ready/out_last : output stream
//   busy, done             : burst in progress / one-cycle completion pulse
//   repeat_cnt, pass_last  : (INPUT_RAM_READER_REPEAT_EN only) pass count-1,
//                            last-word-of-each-pass marker
module input_ram_reader
  import dnn_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   length,
  output logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] ram_data,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
`ifdef INPUT_RAM_READER_REPEAT_EN
  input  logic [3:0]         repeat_cnt,
  output logic               pass_last,
`endif
  output logic               busy,
  output logic               done
);
  localparam int LW = A_WIDTH + 1;
`ifdef INPUT_RAM_READER_REPEAT_EN
  localparam int FW = D_WIDTH + 2;  // {pass_last, last, data}
`else
  localparam int FW = D_WIDTH + 1;  // {last, data}
`endif

  rd_state_e          state_q, state_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      issued_q, issued_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [A_WIDTH-1:0] r_hold_q, r_hold_d;
  logic               infl_q, infl_d;
  logic               infl_last_q, infl_last_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef INPUT_RAM_READER_REPEAT_EN
  logic [A_WIDTH-1:0] base_q, base_d;
  logic [3:0]         rep_q, rep_d;
  logic [3:0]         pass_q, pass_d;
  logic               infl_plast_q, infl_plast_d;
`endif

  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic [1:0]    fifo_count;
  logic          fifo_valid, pop, issue, last_idx, final_pass, head_last;
  logic [2:0]    occ;

  reader_skid_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

`ifdef INPUT_RAM_READER_REPEAT_EN
  assign fifo_wdata = {infl_plast_q, infl_last_q, ram_data};
  assign pass_last  = fifo_valid & fifo_rdata[D_WIDTH+1];
`else
  assign fifo_wdata = {infl_last_q, ram_data};
`endif

  assign fifo_valid = (fifo_count != 2'd0);
  assign pop        = fifo_valid & out_ready;
  assign head_last  = fifo_rdata[D_WIDTH];
  assign out_valid  = fifo_valid;
  assign out_data   = fifo_rdata[D_WIDTH-1:0];
  assign out_last   = fifo_valid & head_last;
  assign busy       = busy_q;
  assign done       = done_q;

  // Words owed to the FIFO once this cycle's pop retires. Counting the pop
  // lets a read issue every cycle at full rate while still never letting
  // queued plus returning data exceed the two slots.
  assign occ = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, pop};

  always_comb begin
    issue      = (state_q == RUN) && (issued_q < len_q) && (occ < 3'd2);
    last_idx   = (issued_q == len_q - LW'(1));
`ifdef INPUT_RAM_READER_REPEAT_EN
    final_pass = (pass_q == rep_q);
`else
    final_pass = 1'b1;
`endif
    // Address is presented in the issue cycle and held afterwards.
    r_addr     = issue ? addr_q : r_hold_q;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    addr_d      = addr_q;
    r_hold_d    = r_addr;
    infl_d      = issue;
    infl_last_d = issue & last_idx & final_pass;
    done_d      = 1'b0;
    busy_d      = done_q ? 1'b0 : busy_q;
`ifdef INPUT_RAM_READER_REPEAT_EN
    base_d       = base_q;
    rep_d        = rep_q;
    pass_d       = pass_q;
    infl_plast_d = issue & last_idx;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = length;
          addr_d   = base_addr;
          issued_d = '0;
`ifdef INPUT_RAM_READER_REPEAT_EN
          base_d   = base_addr;
          rep_d    = repeat_cnt;
          pass_d   = '0;
`endif
          if (length != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;  // empty burst: acknowledge, stay idle
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = addr_q + A_WIDTH'(1);
          issued_d = issued_q + LW'(1);
          if (last_idx) begin
            if (final_pass) begin
              state_d = DRAIN;
            end else begin
`ifdef INPUT_RAM_READER_REPEAT_EN
              // Restart the next pass immediately so there is no bubble.
              addr_d   = base_q;
              issued_d = '0;
              pass_d   = pass_q + 4'd1;
`endif
            end
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      addr_q      <= '0;
      r_hold_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef INPUT_RAM_READER_REPEAT_EN
      base_q       <= '0;
      rep_q        <= '0;
      pass_q       <= '0;
      infl_plast_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      addr_q      <= addr_d;
      r_hold_q    <= r_hold_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef INPUT_RAM_READER_REPEAT_EN
      base_q       <= base_d;
      rep_q        <= rep_d;
      pass_q       <= pass_d;
      infl_plast_q <= infl_plast_d;
`endif
    end
  end
endmodule

// File: tb/tb_input_ram_reader.sv
// Directed bench for input_ram_reader. RAM[i] = 100 + i behind a synchronous
// read port; accepted beats are collected by a negedge monitor.
module tb_input_ram_reader;
  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [3:0]  base_addr, r_addr;
  logic [4:0]  length;
  logic [15:0] ram_data, out_data;
  logic        out_valid, out_last, busy, done;
`ifdef INPUT_RAM_READER_REPEAT_EN
  logic [3:0]  repeat_cnt;
  logic        pass_last;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_ram_reader #(.D_WIDTH(16), .A_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .r_addr    (r_addr),
    .ram_data  (ram_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef INPUT_RAM_READER_REPEAT_EN
    .repeat_cnt(repeat_cnt),
    .pass_last (pass_last),
`endif
    .busy      (busy),
    .done      (done)
  );

  logic [15:0] mem [0:15];
  always @(posedge clk) ram_data <= mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: collect accepted beats, count done pulses, check stall stability.
  logic [15:0] q_data [$];
  bit          q_last [$];
  bit          q_plast[$];
  int          done_cnt = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      chk("fifo_count_le2", dut.u_fifo.count_q <= 2'd2, 1);
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
`ifdef INPUT_RAM_READER_REPEAT_EN
        q_plast.push_back(pass_last);
`else
        q_plast.push_back(1'b0);
`endif
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the cycle right after the capture edge.
  task automatic start_burst(input logic [3:0] b, input logic [4:0] l, input logic [3:0] rc);
    start = 1'b1; base_addr = b; length = l;
`ifdef INPUT_RAM_READER_REPEAT_EN
    repeat_cnt = rc;
`else
    if (rc != 4'd0) $display("note: repeat count ignored in this build");
`endif
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag, output int n);
    n = 0;
    while (!done && n < maxc) begin cyc(); n++; end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    logic [3:0] a;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) mem[i] = 16'(100 + i);
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; length = '0;
`ifdef INPUT_RAM_READER_REPEAT_EN
    repeat_cnt = '0;
`endif
    cyc(); cyc();
    rst = 1'b0; #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", r_addr, 0);

    // Basic burst: base 0, length 4, full rate.
    start_burst(4'd0, 5'd4, 4'd0);             // C1
    chk("t1_raddr0", r_addr, 0);
    chk("t1_busy", busy, 1);
    chk("t1_valid_c1", out_valid, 0);
    cyc();                                      // C2
    chk("t1_valid_c2", out_valid, 0);
    for (int i = 0; i < 4; i++) begin           // C3..C6
      cyc();
      chk($sformatf("t1_valid%0d", i), out_valid, 1);
      chk($sformatf("t1_data%0d", i), out_data, 100 + i);
      chk($sformatf("t1_last%0d", i), out_last, (i == 3) ? 1 : 0);
    end
    cyc();                                      // C7
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 1);
    chk("t1_valid_after", out_valid, 0);
    cyc();
    chk("t1_done_clr", done, 0);
    chk("t1_busy_clr", busy, 0);

    // Wrapping addresses: base 14, length 4.
    start_burst(4'd14, 5'd4, 4'd0);             // C1
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k <= 4) begin
        a = 4'(13 + k);
        chk($sformatf("t2_raddr%0d", k), r_addr, a);
      end
      if (k >= 3) begin
        a = 4'(11 + k);
        chk($sformatf("t2_data%0d", k), out_data, 100 + a);
        chk($sformatf("t2_last%0d", k), out_last, (k == 6) ? 1 : 0);
      end
      if (k < 6) cyc();
    end
    wait_done(10, "t2_done", n);
    cyc();

    // Backpressure: ready pattern 1,0,0,1.
    q_data.delete(); q_last.delete(); q_plast.delete();
    out_ready = pat[0];
    start_burst(4'd0, 5'd8, 4'd0);
    n = 1;
    while (!done && n < 100) begin
      out_ready = pat[n % 4];
      cyc(); n++;
    end
    chk("t3_done", done, 1);
    out_ready = 1'b1;
    cyc();
    chk("t3_count", q_data.size(), 8);
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      chk($sformatf("t3_data%0d", i), q_data[i], 100 + i);
      chk($sformatf("t3_last%0d", i), q_last[i], (i == 7) ? 1 : 0);
    end

    // Zero-length burst.
    q_data.delete(); q_last.delete(); q_plast.delete();
    start_burst(4'd3, 5'd0, 4'd0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    cyc();
    chk("t4_done_clr", done, 0);
    chk("t4_busy_clr", busy, 0);
    cyc(); cyc();
    chk("t4_no_beats", q_data.size(), 0);

    // Full-depth burst with an ignored second start.
    q_data.delete(); q_last.delete(); q_plast.delete();
    d0 = done_cnt;
    start_burst(4'd0, 5'd16, 4'd0);
    cyc(); cyc();
    start_burst(4'd5, 5'd3, 4'd0);
    wait_done(60, "t4b_done", n);
    cyc(); cyc(); cyc();
    chk("t4b_count", q_data.size(), 16);
    chk("t4b_done_cnt", done_cnt - d0, 1);
    chk("t4b_idle", out_valid, 0);
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      chk($sformatf("t4b_data%0d", i), q_data[i], 100 + i);
      chk($sformatf("t4b_last%0d", i), q_last[i], (i == 15) ? 1 : 0);
    end

    // Reset on the third beat of a length-10 burst.
    start_burst(4'd0, 5'd10, 4'd0);             // C1
    cyc(); cyc(); cyc(); cyc();                 // C5
    chk("t5_beat3", out_data, 102);
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    d0 = done_cnt;
    cyc(); cyc(); cyc();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_quiet", out_valid, 0);
    q_data.delete(); q_last.delete(); q_plast.delete();
    start_burst(4'd5, 5'd2, 4'd0);
    wait_done(10, "t5b_done", n);
    cyc();
    chk("t5b_count", q_data.size(), 2);
    if (q_data.size() == 2) begin
      chk("t5b_d0", q_data[0], 105);
      chk("t5b_d1", q_data[1], 106);
      chk("t5b_l0", q_last[0], 0);
      chk("t5b_l1", q_last[1], 1);
    end

`ifdef INPUT_RAM_READER_REPEAT_EN
    // Replay: base 3, length 2, three passes back-to-back.
    q_data.delete(); q_last.delete(); q_plast.delete();
    start_burst(4'd3, 5'd2, 4'd2);
    wait_done(40, "t6_done", n);
    chk("t6_cycles", n, 8);
    cyc();
    chk("t6_count", q_data.size(), 6);
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      chk($sformatf("t6_data%0d", i), q_data[i], 103 + (i % 2));
      chk($sformatf("t6_plast%0d", i), q_plast[i], i % 2);
      chk($sformatf("t6_last%0d", i), q_last[i], (i == 5) ? 1 : 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
